// File: rtl/ttl_quad_pkg.sv
// Shared phase encodings, direction codes and AB transition classification for the quadrature front end.
// Pure package: no latency, no flow control.
package ttl_quad_pkg;

  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b01;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b10;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [1:0] {
    TR_NONE = 2'd0,
    TR_FWD  = 2'd1,
    TR_REV  = 2'd2,
    TR_ILL  = 2'd3
  } trans_t;

  function automatic logic [1:0] fwd_next(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH0:     nxt = PH1;
      PH1:     nxt = PH2;
      PH2:     nxt = PH3;
      default: nxt = PH0;
    endcase
    return nxt;
  endfunction

  // Anything that is neither a hold nor a single forward/reverse step is a double-bit change.
  function automatic trans_t classify(input logic [1:0] prev, input logic [1:0] cur);
    trans_t tr;
    if (cur == prev)                tr = TR_NONE;
    else if (cur == fwd_next(prev)) tr = TR_FWD;
    else if (prev == fwd_next(cur)) tr = TR_REV;
    else                            tr = TR_ILL;
    return tr;
  endfunction

endpackage

// File: rtl/ttl_sync_filter.sv
// Synchronizer for one async pin, plus a stability filter when QUAD_GLITCH_FILTER_EN is defined.
// Latency SYNC_STAGES cycles (+FILTER_LEN with the filter); free-running, no backpressure.
module ttl_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("FILTER_LEN must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], din};
  end

`ifdef QUAD_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [CW-1:0] stable_cnt;
  logic          filt;

  // Counter tracks how long the synchronized value has disagreed with the accepted one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      filt       <= 1'b0;
    end else if (sync[SYNC_STAGES-1] == filt) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CW'(FILTER_LEN - 1)) begin
      filt       <= sync[SYNC_STAGES-1];
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + CW'(1);
    end
  end

  assign dout = filt;
`else
  assign dout = sync[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/ttl_quad_count_driver.sv
// x4 quadrature decoder producing SET/LD_n/CNT_n/UP_n strobes for a 10-bit up/down counter (filter: QUAD_GLITCH_FILTER_EN).
// Pin edge to CNT_n is SYNC_STAGES+1 cycles (+FILTER_LEN filtered); all outputs registered, no backpressure.
module ttl_quad_count_driver
  import ttl_quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  input  logic             IDX,
  input  logic             idx_arm,
  input  logic             preset,
  input  logic             err_clr,
  output logic             SET,
  output logic             LD_n,
  output logic             CNT_n,
  output logic             UP_n,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  logic       a_f;
  logic       b_f;
  logic       idx_f;
  logic [1:0] ab;
  logic [1:0] prev_ab;
  logic       prev_idx;
  logic       seeded;
  trans_t     tr;

  ttl_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sync_a (
    .clk(clk), .rst_n(rst_n), .din(A), .dout(a_f)
  );
  ttl_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sync_b (
    .clk(clk), .rst_n(rst_n), .din(B), .dout(b_f)
  );
  ttl_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sync_idx (
    .clk(clk), .rst_n(rst_n), .din(IDX), .dout(idx_f)
  );

  assign ab = {a_f, b_f};
  assign tr = classify(prev_ab, ab);

  // The first cycle after release only captures the phase, so a reset never produces a count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seeded   <= 1'b0;
      prev_ab  <= PH0;
      prev_idx <= 1'b0;
      SET      <= 1'b0;
      LD_n     <= 1'b1;
      CNT_n    <= 1'b1;
      UP_n     <= DIR_UP;
    end else begin
      seeded   <= 1'b1;
      prev_ab  <= ab;
      prev_idx <= idx_f;
      SET      <= preset;
      LD_n     <= !(seeded && idx_f && !prev_idx && idx_arm);
      CNT_n    <= !(seeded && (tr == TR_FWD || tr == TR_REV));
      if (seeded && tr == TR_FWD)      UP_n <= DIR_UP;
      else if (seeded && tr == TR_REV) UP_n <= DIR_DN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (err_clr) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (seeded && tr == TR_ILL) begin
      err <= 1'b1;
      if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_ttl_quad_count_driver.sv
// Scoreboard bench: stimulus pushes expected strobes with their due cycle, a negedge monitor pops and compares.
// A behavioural 10-bit counter on the strobes lets the position model be checked end to end.
module tb_ttl_quad_count_driver;

  localparam int SYNC = 2;
  localparam int FLEN = 4;
`ifdef QUAD_GLITCH_FILTER_EN
  localparam int LAT  = SYNC + 1 + FLEN;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = SYNC + 1;
  localparam bit FILT = 1'b0;
`endif
  localparam logic [9:0] D_VAL = 10'h155;

  logic       clk = 1'b0;
  logic       rst_n, A, B, IDX, idx_arm, preset, err_clr;
  logic       SET, LD_n, CNT_n, UP_n, err;
  logic [7:0] err_cnt;
  logic [9:0] q;

  ttl_quad_count_driver #(.SYNC_STAGES(SYNC), .FILTER_LEN(FLEN), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .IDX(IDX), .idx_arm(idx_arm),
    .preset(preset), .err_clr(err_clr), .SET(SET), .LD_n(LD_n), .CNT_n(CNT_n),
    .UP_n(UP_n), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Downstream counter: SET, then load, then count.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= '0;
    else if (SET)   q <= '1;
    else if (!LD_n) q <= D_VAL;
    else if (!CNT_n) q <= UP_n ? q - 10'd1 : q + 10'd1;
  end

  typedef struct {
    int   cyc;
    logic up_n;
  } cnt_ev_t;

  cnt_ev_t cnt_q[$];
  int      ld_q[$];
  int      set_q[$];
  int      checks   = 0;
  int      failures = 0;

  // Reference model state: phase index 0..3 along the forward sequence.
  int   ph;
  int   dir_exp;
  int   err_n;
  int   err_exp;
  int   q_exp;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cnt_ev_t ev;
    int      t;
    if (!rst_n) begin
      check("reset_strobes", int'({SET, LD_n, CNT_n, UP_n, err}), int'(5'b01100));
      check("reset_err_cnt", int'(err_cnt), 0);
    end else begin
      if (!CNT_n) begin
        if (cnt_q.size() == 0) check("unexpected_cnt", cyc, -1);
        else begin
          ev = cnt_q.pop_front();
          check("cnt_cycle", cyc, ev.cyc);
          check("cnt_dir", int'(UP_n), int'(ev.up_n));
        end
      end
      if (!LD_n) begin
        if (ld_q.size() == 0) check("unexpected_ld", cyc, -1);
        else begin
          t = ld_q.pop_front();
          check("ld_cycle", cyc, t);
        end
      end
      if (SET) begin
        if (set_q.size() == 0) check("unexpected_set", cyc, -1);
        else begin
          t = set_q.pop_front();
          check("set_cycle", cyc, t);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    ph = 0; dir_exp = 0; err_n = 0; err_exp = 0; q_exp = 0;
  endtask

  // Phase index from pins: gray 00,01,11,10 -> 0,1,2,3; the step size mod 4 gives the direction.
  task automatic drive_ab(input logic na, input logic nb, input int tev);
    int      np, diff;
    cnt_ev_t ev;
    np   = (na ? 2 : 0) + ((na ^ nb) ? 1 : 0);
    diff = (np - ph + 4) % 4;
    if (diff == 1) begin
      ev.cyc = tev; ev.up_n = 1'b0; cnt_q.push_back(ev);
      dir_exp = 0; q_exp = (q_exp + 1) % 1024;
    end else if (diff == 3) begin
      ev.cyc = tev; ev.up_n = 1'b1; cnt_q.push_back(ev);
      dir_exp = 1; q_exp = (q_exp + 1023) % 1024;
    end else if (diff == 2) begin
      err_exp = 1;
      err_n   = (err_n < 255) ? err_n + 1 : 255;
    end
    A  = na;
    B  = nb;
    ph = np;
  endtask

  task automatic step(input int d, input int gap);
    int   np;
    logic na;
    tick(1);
    np = (ph + d + 4) % 4;
    na = (np >= 2);
    drive_ab(na, na ^ (np % 2 == 1), cyc + LAT);
    tick(gap);
  endtask

  task automatic check_static(input string tag);
    check({tag, "_q"}, int'(q), q_exp);
    check({tag, "_up_n"}, int'(UP_n), dir_exp);
    check({tag, "_err"}, int'(err), err_exp);
    check({tag, "_err_cnt"}, int'(err_cnt), err_n);
    check({tag, "_pending"}, cnt_q.size() + ld_q.size() + set_q.size(), 0);
  endtask

  task automatic idx_pulse(input logic arm);
    tick(1);
    idx_arm = arm;
    tick(2);
    IDX = 1'b1;
    if (arm) begin
      ld_q.push_back(cyc + LAT);
      q_exp = int'(D_VAL);
    end
    tick(6);
    IDX = 1'b0;
    tick(LAT + 10);
  endtask

  task automatic preset_pulse();
    tick(1);
    preset = 1'b1;
    set_q.push_back(cyc + 1);
    q_exp = 1023;
    tick(1);
    preset = 1'b0;
    tick(4);
  endtask

  task automatic err_clear();
    tick(1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    err_exp = 0;
    err_n   = 0;
    tick(3);
  endtask

  task automatic glitch_a(input int w);
    logic oa;
    tick(1);
    oa = A;
    if (FILT && w < FLEN) begin
      A = ~oa;
      tick(w);
      A = oa;
    end else begin
      drive_ab(~oa, B, cyc + LAT);
      tick(w);
      drive_ab(oa, B, cyc + LAT);
    end
    tick(LAT + 10);
  endtask

  initial begin
    int act;
    rst_n = 1'b0; A = 1'b0; B = 1'b0; IDX = 1'b0;
    idx_arm = 1'b0; preset = 1'b0; err_clr = 1'b0;
    model_reset();

    // Pins toggle while reset is held, then park at 00 before release.
    repeat (10) begin
      tick(1);
      A = 1'($urandom);
      B = 1'($urandom);
    end
    A = 1'b0; B = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(LAT + 12);
    check_static("post_reset");

    repeat (32) step(1, 19);
    tick(LAT + 4);
    check_static("forward32");

    step(-1, LAT + 6);
    check_static("one_reverse");

    // Mid-operation reset: outputs must drop at once, without waiting for a clock.
    tick(1);
    rst_n = 1'b0;
    #1;
    check("midrst_strobes", int'({SET, LD_n, CNT_n, UP_n, err}), int'(5'b01100));
    A = 1'b0; B = 1'b0;
    model_reset();
    tick(5);
    rst_n = 1'b1;
    tick(LAT + 12);
    check_static("post_midrst");

    repeat (5) step(-1, 19);
    check_static("reverse5");
    repeat (2) step(1, 19);
    check_static("rev_then_fwd");

    step(2, LAT + 6);
    check_static("illegal1");
    repeat (299) step(2, LAT + 4);
    tick(4);
    check_static("illegal300");
    err_clear();
    check_static("err_clear");

    idx_pulse(1'b1);
    check_static("idx_armed");
    step(1, LAT + 6);
    idx_pulse(1'b0);
    check_static("idx_disarmed");

    preset_pulse();
    check_static("preset");

    glitch_a(3);
    check_static("glitch3");
    glitch_a(6);
    check_static("pulse6");

    repeat (150) begin
      act = int'($urandom_range(0, 7));
      case (act)
        0: step(1, LAT + 8);
        1: step(-1, LAT + 8);
        2: step(0, LAT + 8);
        3: step(2, LAT + 8);
        4: idx_pulse(1'($urandom));
        5: preset_pulse();
        6: err_clear();
        default: glitch_a(int'($urandom_range(1, 8)));
      endcase
      tick(2);
      check_static("random");
    end

    tick(LAT + 10);
    check("final_pending", cnt_q.size() + ld_q.size() + set_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
